// File: rtl/ram_banked_2r1w_if.sv
// Request/response bundle for the banked 2-read/1-write memory.
// The master drives requests; the slave (memory) returns read data and status.
interface ram_banked_2r1w_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 21
);
    logic                  wr;
    logic [DATA_W/8-1:0]   wr_be;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     d_in;
    logic                  rd_en_a;
    logic                  rd_en_b;
    logic [ADDR_W-1:0]     rd_addr_a;
    logic [ADDR_W-1:0]     rd_addr_b;
    logic [DATA_W-1:0]     d_out_a;
    logic [DATA_W-1:0]     d_out_b;
    logic                  vld_a;
    logic                  vld_b;
    logic                  busy;
    logic                  wr_drop;

    modport master (
        output wr, wr_be, wr_addr, d_in, rd_en_a, rd_en_b, rd_addr_a, rd_addr_b,
        input  d_out_a, d_out_b, vld_a, vld_b, busy, wr_drop
    );

    modport slave (
        input  wr, wr_be, wr_addr, d_in, rd_en_a, rd_en_b, rd_addr_a, rd_addr_b,
        output d_out_a, d_out_b, vld_a, vld_b, busy, wr_drop
    );
endinterface

// File: rtl/ram_banked_2r1w.sv
// Banked memory, two registered read ports and one byte-enabled write port,
// write-first forwarding, and a post-reset sweep that zeroes every word.
module ram_banked_2r1w #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 21,
    parameter int BANK_BITS = 3
) (
    input logic              clk,
    input logic              reset,
    ram_banked_2r1w_if.slave bus
);
    localparam int BE_W   = DATA_W / 8;
    localparam int ROW_W  = ADDR_W - BANK_BITS;
    localparam int BANKS  = 1 << BANK_BITS;
    localparam int ROWS   = 1 << ROW_W;
    localparam int BSEL_W = (BANK_BITS > 0) ? BANK_BITS : 1;

    typedef enum logic {CLEAR, READY} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   clr_row_q, clr_row_d;
    logic               busy;
    logic               wr_acc, rd_acc_a, rd_acc_b;
    logic [BSEL_W-1:0]  wr_bank, bank_a, bank_b;
    logic [ROW_W-1:0]   wr_row, row_a, row_b;
    logic [ROW_W-1:0]   w_row;
    logic [BE_W-1:0]    w_be;
    logic [DATA_W-1:0]  w_data;
    logic [DATA_W-1:0]  bank_rd_a [BANKS];
    logic [DATA_W-1:0]  bank_rd_b [BANKS];

    logic               vld_a_q, vld_a_d, vld_b_q, vld_b_d;
    logic               wr_drop_q, wr_drop_d;
    logic [BSEL_W-1:0]  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [BE_W-1:0]    fwd_be_a_q, fwd_be_a_d, fwd_be_b_q, fwd_be_b_d;
    logic [DATA_W-1:0]  fwd_data_q, fwd_data_d;
    logic [DATA_W-1:0]  hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic [DATA_W-1:0]  merged_a, merged_b;

    // With BANK_BITS=0 the shift leaves nothing, so every address maps to bank 0.
    assign wr_bank = BSEL_W'(bus.wr_addr   >> ROW_W);
    assign bank_a  = BSEL_W'(bus.rd_addr_a >> ROW_W);
    assign bank_b  = BSEL_W'(bus.rd_addr_b >> ROW_W);
    assign wr_row  = ROW_W'(bus.wr_addr);
    assign row_a   = ROW_W'(bus.rd_addr_a);
    assign row_b   = ROW_W'(bus.rd_addr_b);

    assign busy     = (state_q == CLEAR);
    assign wr_acc   = bus.wr && !busy;
    assign rd_acc_a = bus.rd_en_a && !busy;
    assign rd_acc_b = bus.rd_en_b && !busy;

    always_comb begin
        state_d   = state_q;
        clr_row_d = clr_row_q;
        if (state_q == CLEAR) begin
            clr_row_d = clr_row_q + 1'b1;
            if (clr_row_q == ROW_W'(ROWS - 1)) begin
                state_d   = READY;
                clr_row_d = '0;
            end
        end
    end

    // The sweep shares the write port: zeroes go to the same row of every bank.
    always_comb begin
        w_row  = busy ? clr_row_q : wr_row;
        w_be   = busy ? {BE_W{1'b1}} : bus.wr_be;
        w_data = busy ? '0 : bus.d_in;
    end

    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [ROWS];
            logic [DATA_W-1:0] rd_a_q;
            logic [DATA_W-1:0] rd_b_q;
            logic              we;

            assign we = busy || (wr_acc && (wr_bank == BSEL_W'(gi)));

            always_ff @(posedge clk) begin
                if (we) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (w_be[b]) mem[w_row][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
                if (rd_acc_a && (bank_a == BSEL_W'(gi))) rd_a_q <= mem[row_a];
                if (rd_acc_b && (bank_b == BSEL_W'(gi))) rd_b_q <= mem[row_b];
            end

            assign bank_rd_a[gi] = rd_a_q;
            assign bank_rd_b[gi] = rd_b_q;
        end
    endgenerate

    // Arrays return pre-write data, so same-cycle write bytes are remembered
    // and overlaid on the registered read to give write-first behaviour.
    always_comb begin
        vld_a_d    = rd_acc_a;
        vld_b_d    = rd_acc_b;
        wr_drop_d  = bus.wr && busy;
        sel_a_d    = rd_acc_a ? bank_a : sel_a_q;
        sel_b_d    = rd_acc_b ? bank_b : sel_b_q;
        fwd_data_d = bus.d_in;
        fwd_be_a_d = (wr_acc && (bus.wr_addr == bus.rd_addr_a)) ? bus.wr_be : '0;
        fwd_be_b_d = (wr_acc && (bus.wr_addr == bus.rd_addr_b)) ? bus.wr_be : '0;
    end

    always_comb begin
        merged_a = bank_rd_a[sel_a_q];
        merged_b = bank_rd_b[sel_b_q];
        for (int b = 0; b < BE_W; b++) begin
            if (fwd_be_a_q[b]) merged_a[8*b +: 8] = fwd_data_q[8*b +: 8];
            if (fwd_be_b_q[b]) merged_b[8*b +: 8] = fwd_data_q[8*b +: 8];
        end
        hold_a_d = vld_a_q ? merged_a : hold_a_q;
        hold_b_d = vld_b_q ? merged_b : hold_b_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CLEAR;
            clr_row_q  <= '0;
            vld_a_q    <= 1'b0;
            vld_b_q    <= 1'b0;
            wr_drop_q  <= 1'b0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            fwd_be_a_q <= '0;
            fwd_be_b_q <= '0;
            fwd_data_q <= '0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_row_q  <= clr_row_d;
            vld_a_q    <= vld_a_d;
            vld_b_q    <= vld_b_d;
            wr_drop_q  <= wr_drop_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            fwd_be_a_q <= fwd_be_a_d;
            fwd_be_b_q <= fwd_be_b_d;
            fwd_data_q <= fwd_data_d;
            hold_a_q   <= hold_a_d;
            hold_b_q   <= hold_b_d;
        end
    end

    assign bus.d_out_a = hold_a_d;
    assign bus.d_out_b = hold_b_d;
    assign bus.vld_a   = vld_a_q;
    assign bus.vld_b   = vld_b_q;
    assign bus.busy    = busy;
    assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_ram_banked_2r1w.sv
// Self-checking bench: fixed vectors, sweep/reset sequences and random traffic
// compared against a word-array model of the memory.
module tb_ram_banked_2r1w;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int BANK_BITS = 2;
    localparam int SWEEP     = 1 << (ADDR_W - BANK_BITS);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ram_banked_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_banked_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_BITS(BANK_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] ref_mem [256];
    int          sweep_left;
    logic [15:0] exp_da, exp_db;
    logic        exp_va, exp_vb, exp_drop;

    typedef struct {
        logic        w;
        logic [1:0]  be;
        logic [7:0]  wa;
        logic [15:0] din;
        logic        ea;
        logic [7:0]  aa;
        logic        eb;
        logic [7:0]  ab;
        logic        ca;
        logic [15:0] xa;
        logic        cb;
        logic [15:0] xb;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = nw[7:0];
        if (be[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    // One clock of traffic; the model applies the write before answering reads,
    // which is exactly what write-first means at word level.
    task automatic step(input logic w, input logic [1:0] be, input logic [7:0] wa,
                        input logic [15:0] din, input logic ea, input logic [7:0] aa,
                        input logic eb, input logic [7:0] ab);
        logic busy_m;
        bus.wr = w; bus.wr_be = be; bus.wr_addr = wa; bus.d_in = din;
        bus.rd_en_a = ea; bus.rd_addr_a = aa; bus.rd_en_b = eb; bus.rd_addr_b = ab;
        busy_m   = (sweep_left > 0);
        exp_drop = w && busy_m;
        if (w && !busy_m) ref_mem[wa] = merge(ref_mem[wa], din, be);
        exp_va = ea && !busy_m;
        exp_vb = eb && !busy_m;
        if (exp_va) exp_da = ref_mem[aa];
        if (exp_vb) exp_db = ref_mem[ab];
        if (busy_m) sweep_left--;
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d wr=%b be=%b wa=%h din=%h ra=%b:%h rb=%b:%h -> a=%b:%h b=%b:%h busy=%b drop=%b",
                 cyc, w, be, wa, din, ea, aa, eb, ab, bus.vld_a, bus.d_out_a,
                 bus.vld_b, bus.d_out_b, bus.busy, bus.wr_drop);
        chk("vld_a",   32'(bus.vld_a),   32'(exp_va));
        chk("vld_b",   32'(bus.vld_b),   32'(exp_vb));
        chk("d_out_a", 32'(bus.d_out_a), 32'(exp_da));
        chk("d_out_b", 32'(bus.d_out_b), 32'(exp_db));
        chk("wr_drop", 32'(bus.wr_drop), 32'(exp_drop));
        chk("busy",    32'(bus.busy),    32'(sweep_left > 0));
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        bus.wr = 1'b0; bus.wr_be = '0; bus.wr_addr = '0; bus.d_in = '0;
        bus.rd_en_a = 1'b0; bus.rd_addr_a = '0; bus.rd_en_b = 1'b0; bus.rd_addr_b = '0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d reset asserted", cyc);
        chk("rst_d_out_a", 32'(bus.d_out_a), 32'h0);
        chk("rst_d_out_b", 32'(bus.d_out_b), 32'h0);
        chk("rst_vld_a",   32'(bus.vld_a),   32'h0);
        chk("rst_vld_b",   32'(bus.vld_b),   32'h0);
        chk("rst_busy",    32'(bus.busy),    32'h1);
        chk("rst_wr_drop", 32'(bus.wr_drop), 32'h0);
        reset = 1'b1;
        sweep_left = SWEEP;
        exp_da = '0; exp_db = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    // Bounded wait for the sweep to finish; returns the number of busy edges seen.
    task automatic wait_ready(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            idle();
            n++;
        end
    endtask

    function automatic logic [7:0] pick_addr();
        logic [7:0] pool [4];
        pool[0] = 8'h10; pool[1] = 8'h50; pool[2] = 8'h90; pool[3] = 8'hD0;
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 3)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int n;
        int drops;
        logic [15:0] v;

        vecs[0] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b1, 8'h3F, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vecs[1] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h40, 1'b1, 8'hFF, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vecs[2] = '{1'b1, 2'b11, 8'h41, 16'hBEEF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[3] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h41, 1'b1, 8'hC1, 1'b1, 16'hBEEF, 1'b1, 16'h0000};
        vecs[4] = '{1'b1, 2'b01, 8'h41, 16'h1234, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 16'hBE34, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h41, 1'b1, 8'h41, 1'b1, 16'hBE34, 1'b1, 16'hBE34};
        vecs[6] = '{1'b1, 2'b10, 8'hC1, 16'hA5A5, 1'b0, 8'h00, 1'b1, 8'hC1, 1'b0, 16'h0000, 1'b1, 16'hA500};
        vecs[7] = '{1'b1, 2'b00, 8'h41, 16'hFFFF, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 16'hBE34, 1'b0, 16'h0000};
        vecs[8] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h41, 1'b1, 8'hC1, 1'b1, 16'hBE34, 1'b1, 16'hA500};

        sweep_left = SWEEP;
        @(posedge clk);
        #1;
        do_reset();
        wait_ready(n);
        chk("sweep_len_first", 32'(n), 32'(SWEEP));

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].w, vecs[i].be, vecs[i].wa, vecs[i].din,
                 vecs[i].ea, vecs[i].aa, vecs[i].eb, vecs[i].ab);
            if (vecs[i].ca) chk("vec_a", 32'(bus.d_out_a), 32'(vecs[i].xa));
            if (vecs[i].cb) chk("vec_b", 32'(bus.d_out_b), 32'(vecs[i].xb));
        end

        // Write and reads during the sweep are dropped.
        do_reset();
        drops = 0;
        for (int i = 0; i < SWEEP; i++) begin
            step(i == 10, 2'b11, 8'h22, 16'hFFFF, 1'b1, 8'(i), 1'b1, 8'h22);
            if (bus.wr_drop) drops++;
        end
        chk("drop_count", 32'(drops), 32'd1);
        chk("busy_after_sweep", 32'(bus.busy), 32'h0);
        step(1'b0, 2'b00, 8'h00, 16'h0, 1'b1, 8'h22, 1'b0, 8'h00);
        chk("dropped_write_absent", 32'(bus.d_out_a), 32'h0);

        // Fill memory, then interrupt the following sweep with a second reset.
        for (int a = 0; a < 256; a++) step(1'b1, 2'b11, 8'(a), 16'(a), 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 2'b00, 8'h00, 16'h0, 1'b1, 8'hAB, 1'b1, 8'h3C);
        chk("fill_a", 32'(bus.d_out_a), 32'h00AB);
        do_reset();
        for (int i = 0; i < 30; i++) idle();
        do_reset();
        wait_ready(n);
        chk("sweep_len_restart", 32'(n), 32'(SWEEP));
        for (int a = 0; a < 256; a++) begin
            step(1'b0, 2'b00, 8'h00, 16'h0, 1'b1, 8'(a), 1'b1, 8'(255 - a));
            if (bus.d_out_a !== 16'h0 || bus.d_out_b !== 16'h0)
                chk("cleared", 32'(bus.d_out_a | bus.d_out_b), 32'h0);
        end

        // Same-address dual reads under a stream of incrementing writes.
        for (int i = 0; i < 20; i++) begin
            v = ref_mem[8'h7E] + 16'd1;
            step(1'b1, 2'b11, 8'h7E, v, 1'b1, 8'h7E, 1'b1, 8'h7E);
            chk("inc_fwd_a", 32'(bus.d_out_a), 32'(i + 1));
        end

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pick_addr(),
                 16'($urandom), 1'($urandom_range(0, 1)), pick_addr(),
                 1'($urandom_range(0, 1)), pick_addr());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
